// File: rtl/galaksija_tape_pkg.sv
// Shared types and defaults for the Galaksija cassette player.
package galaksija_tape_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEADER,
      ST_PRIME,
      ST_DATA,
      ST_FINISH
   } tape_state_t;

   // Edges from a ram_addr change to the edge that may capture ram_q
   localparam int unsigned RAM_LAT          = 2;

   localparam int unsigned DEF_BIT_CYC      = 2048;
   localparam int unsigned DEF_PULSE_CYC    = 256;
   localparam int unsigned DEF_LEADER_BYTES = 96;

   // Pulse level at position c of a cell: pulse at start, second pulse at half cell for a 1
   function automatic logic cell_level(input int unsigned c, input logic b,
                                       input int unsigned bit_cyc, input int unsigned pulse_cyc);
      int unsigned half;
      half = bit_cyc / 2;
      return (c < pulse_cyc) || (b && (c >= half) && (c < half + pulse_cyc));
   endfunction

endpackage

// File: rtl/galaksija_tape_bit_gen.sv
// One bit cell generator: owns the cell counter and the registered pulse output.
module galaksija_tape_bit_gen
   import galaksija_tape_pkg::*;
#(
   parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
   parameter int unsigned PULSE_CYC = DEF_PULSE_CYC
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic cell_start,
   input  logic bit_in,
   output logic tape_out,
   output logic cell_last_c
);

   localparam int unsigned CW = $clog2(BIT_CYC);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

   logic [CW-1:0] cnt;
   logic          cur_bit;
   logic          active;

   assign cell_last_c = active && (cnt == LAST);

   // Cell counter and pulse level, registered against the counter value of the next cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         cur_bit  <= 1'b0;
         active   <= 1'b0;
         tape_out <= 1'b0;
      end else if (clear) begin
         cnt      <= '0;
         active   <= 1'b0;
         tape_out <= 1'b0;
      end else if (cell_start) begin
         cnt      <= '0;
         cur_bit  <= bit_in;
         active   <= 1'b1;
         tape_out <= cell_level(32'd0, bit_in, BIT_CYC, PULSE_CYC);
      end else if (active) begin
         if (cnt == LAST) begin
            cnt      <= '0;
            active   <= 1'b0;
            tape_out <= 1'b0;
         end else begin
            cnt      <= cnt + CW'(1);
            tape_out <= cell_level(32'(cnt) + 32'd1, cur_bit, BIT_CYC, PULSE_CYC);
         end
      end
   end

endmodule

// File: rtl/galaksija_tape_player.sv
// Plays the tape buffer as a Galaksija cassette pulse stream: leader, then bytes LSB-first.
module galaksija_tape_player
   import galaksija_tape_pkg::*;
#(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned BIT_CYC      = DEF_BIT_CYC,
   parameter int unsigned PULSE_CYC    = DEF_PULSE_CYC,
   parameter int unsigned LEADER_BYTES = DEF_LEADER_BYTES
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [7:0]        ram_q,
   output logic              tape_out,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   byte_pos
);

   localparam int unsigned LEAD_CELLS = LEADER_BYTES * 8;
   localparam int unsigned LW = (LEAD_CELLS > 2) ? $clog2(LEAD_CELLS) : 1;
   localparam int unsigned FW = $clog2(RAM_LAT + 1);

   tape_state_t       state, state_nx;
   logic [7:0]        shift, next_byte;
   logic [2:0]        bit_idx;
   logic [LW-1:0]     lead_cnt;
   logic [FW-1:0]     fetch_cnt;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   byte_pos_inc;
   logic              more_c;

   logic              accept_c, cell_start_c, cell_bit_c, fetch_go_c;
   logic              load_next_c, load_ram_c, shift_c, lead_step_c, byte_step_c, stop_c;
   logic [ADDR_W-1:0] fetch_addr_c;
   logic              cell_last_c;

   assign byte_pos_inc = byte_pos + (ADDR_W + 1)'(1);
   assign more_c       = byte_pos_inc < len_q;

   galaksija_tape_bit_gen #(
      .BIT_CYC   (BIT_CYC),
      .PULSE_CYC (PULSE_CYC)
   ) u_bit_gen (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (stop_c),
      .cell_start  (cell_start_c),
      .bit_in      (cell_bit_c),
      .tape_out    (tape_out),
      .cell_last_c (cell_last_c)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next state and datapath strobes; stop overrides everything outside IDLE
   always_comb begin
      state_nx     = state;
      accept_c     = 1'b0;
      cell_start_c = 1'b0;
      cell_bit_c   = 1'b0;
      fetch_go_c   = 1'b0;
      fetch_addr_c = ram_addr;
      load_next_c  = 1'b0;
      load_ram_c   = 1'b0;
      shift_c      = 1'b0;
      lead_step_c  = 1'b0;
      byte_step_c  = 1'b0;
      stop_c       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !stop && (length != '0)) begin
               accept_c = 1'b1;
               if (LEADER_BYTES > 0) begin
                  state_nx     = ST_LEADER;
                  cell_start_c = 1'b1;
               end else begin
                  state_nx     = ST_PRIME;
                  fetch_go_c   = 1'b1;
                  fetch_addr_c = '0;
               end
            end
         end
         ST_LEADER: begin
            if (cell_last_c) begin
               lead_step_c  = 1'b1;
               cell_start_c = 1'b1;
               if (lead_cnt == LW'(LEAD_CELLS - 1)) begin
                  state_nx    = ST_DATA;
                  cell_bit_c  = next_byte[0];
                  load_next_c = 1'b1;
               end else if (lead_cnt == LW'(LEAD_CELLS - 2)) begin
                  // byte 0 is fetched while the last leader cell plays
                  fetch_go_c   = 1'b1;
                  fetch_addr_c = '0;
               end
            end
         end
         ST_PRIME: begin
            if (fetch_cnt == FW'(1)) begin
               state_nx     = ST_DATA;
               cell_start_c = 1'b1;
               cell_bit_c   = ram_q[0];
               load_ram_c   = 1'b1;
            end
         end
         ST_DATA: begin
            if (cell_last_c) begin
               if (bit_idx == 3'd7) begin
                  byte_step_c = 1'b1;
                  if (more_c) begin
                     cell_start_c = 1'b1;
                     cell_bit_c   = next_byte[0];
                     load_next_c  = 1'b1;
                  end else begin
                     state_nx = ST_FINISH;
                  end
               end else begin
                  cell_start_c = 1'b1;
                  cell_bit_c   = shift[1];
                  shift_c      = 1'b1;
                  // prefetch next byte at the start of bit 7, never past the last byte
                  if ((bit_idx == 3'd6) && more_c) begin
                     fetch_go_c   = 1'b1;
                     fetch_addr_c = ram_addr + ADDR_W'(1);
                  end
               end
            end
         end
         ST_FINISH: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
      if (stop && (state != ST_IDLE)) begin
         stop_c       = 1'b1;
         state_nx     = ST_IDLE;
         accept_c     = 1'b0;
         cell_start_c = 1'b0;
         fetch_go_c   = 1'b0;
         load_next_c  = 1'b0;
         load_ram_c   = 1'b0;
         shift_c      = 1'b0;
         lead_step_c  = 1'b0;
         byte_step_c  = 1'b0;
      end
   end

   // Address, fetch pipeline, shift/next-byte registers, counters and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr  <= '0;
         fetch_cnt <= '0;
         next_byte <= '0;
         shift     <= '0;
         bit_idx   <= '0;
         lead_cnt  <= '0;
         len_q     <= '0;
         byte_pos  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         busy <= (state_nx != ST_IDLE);
         done <= (state_nx == ST_FINISH);
         if (accept_c) begin
            len_q    <= length;
            byte_pos <= '0;
            lead_cnt <= '0;
         end
         if (fetch_go_c) begin
            ram_addr  <= fetch_addr_c;
            fetch_cnt <= FW'(RAM_LAT);
         end else if (stop_c) begin
            fetch_cnt <= '0;
         end else if (fetch_cnt != '0) begin
            fetch_cnt <= fetch_cnt - FW'(1);
         end
         if (fetch_cnt == FW'(1)) next_byte <= ram_q;
         if (load_next_c) begin
            shift   <= next_byte;
            bit_idx <= '0;
         end else if (load_ram_c) begin
            shift   <= ram_q;
            bit_idx <= '0;
         end else if (shift_c) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (lead_step_c) lead_cnt <= lead_cnt + LW'(1);
         if (byte_step_c) byte_pos <= byte_pos_inc;
      end
   end

endmodule

// File: tb/tb_galaksija_tape_player.sv
// Scoreboard bench: expected pulse/done events are queued at stimulus time, a monitor pops them.
module tb_galaksija_tape_player;

   localparam int BC = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   // dut1: one leader byte; dut0: no leader
   logic        start1 = 1'b0, stop1 = 1'b0, start0 = 1'b0, stop0 = 1'b0;
   logic [14:0] len1 = '0, len0 = '0, pos1, pos0;
   logic [13:0] addr1, addr0;
   logic [7:0]  q1, q0;
   logic        tape1, busy1, done1, tape0, busy0, done0;
   logic [7:0]  mem1 [0:15];
   logic [7:0]  mem0 [0:15];

   galaksija_tape_player #(.ADDR_W(14), .BIT_CYC(16), .PULSE_CYC(2), .LEADER_BYTES(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop1), .length(len1),
      .ram_addr(addr1), .ram_q(q1), .tape_out(tape1), .busy(busy1), .done(done1), .byte_pos(pos1));

   galaksija_tape_player #(.ADDR_W(14), .BIT_CYC(16), .PULSE_CYC(2), .LEADER_BYTES(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .stop(stop0), .length(len0),
      .ram_addr(addr0), .ram_q(q0), .tape_out(tape0), .busy(busy0), .done(done0), .byte_pos(pos0));

   // RAM port B: ram_q valid two edges after ram_addr changes
   always @(posedge clk) begin
      q1 <= mem1[addr1[3:0]];
      q0 <= mem0[addr0[3:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {bit is_done; int t; int pos;} ev_t;
   ev_t sbq1[$];
   ev_t sbq0[$];

   int  n_checks = 0;
   int  n_errors = 0;
   bit  prev1, prev0, track;
   int  addr_max;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push(input bit d0, input bit is_done, input int t, input int pos);
      ev_t e;
      e = '{is_done, t, pos};
      if (d0) sbq0.push_back(e);
      else    sbq1.push_back(e);
   endtask

   // Expected events of a play started (start driven) in cycle t0; emit<0 means full play with done
   task automatic push_play(input bit d0, input int t0, input int lead, input logic [31:0] data,
                            input int nbytes, input int emit);
      int first, total, lim;
      bit b;
      first = t0 + 1 + ((lead == 0) ? 2 : 0);
      total = (lead + nbytes) * 8;
      lim   = (emit < 0) ? total : emit;
      for (int i = 0; i < lim; i++) begin
         b = (i < lead * 8) ? 1'b0 : data[i - lead * 8];
         push(d0, 1'b0, first + BC * i, 0);
         if (b) push(d0, 1'b0, first + BC * i + BC / 2, 0);
      end
      if (emit < 0) push(d0, 1'b1, first + BC * total, nbytes);
   endtask

   task automatic sb_see(input bit d0, input bit is_done, input int pos);
      ev_t e;
      bit  empty;
      empty = d0 ? (sbq0.size() == 0) : (sbq1.size() == 0);
      n_checks++;
      if (empty) begin
         n_errors++;
         $display("FAIL sb_unexpected dut%0d kind=%0d actual_cycle=%0d required=no_event", d0, is_done, cyc);
      end else begin
         e = d0 ? sbq0.pop_front() : sbq1.pop_front();
         if (e.is_done != is_done || e.t != cyc || (is_done && e.pos != pos)) begin
            n_errors++;
            $display("FAIL sb_event dut%0d actual kind=%0d cycle=%0d pos=%0d required kind=%0d cycle=%0d pos=%0d",
                     d0, is_done, cyc, pos, e.is_done, e.t, e.pos);
         end
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      int t0;
      prev1 = 1'b0; prev0 = 1'b0; track = 1'b0; addr_max = 0;
      for (int i = 0; i < 16; i++) begin mem1[i] = 8'h00; mem0[i] = 8'h00; end

      fork
         forever begin
            @(negedge clk);
            if (tape1 && !prev1) sb_see(1'b0, 1'b0, 0);
            if (done1)           sb_see(1'b0, 1'b1, int'(pos1));
            if (tape0 && !prev0) sb_see(1'b1, 1'b0, 0);
            if (done0)           sb_see(1'b1, 1'b1, int'(pos0));
            prev1 = tape1;
            prev0 = tape0;
            if (track && int'(addr1) > addr_max) addr_max = int'(addr1);
         end
         begin
            #200000;
            $display("FAIL watchdog actual=timeout required=finish");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tape", int'(tape1), 0);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_pos", int'(pos1), 0);
      chk("rst_addr", int'(addr1), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: 0xA5, one byte after one leader byte; done at relative cycle 257
      mem1[0] = 8'hA5;
      t0 = cyc;
      push_play(1'b0, t0, 1, 32'h0000_00A5, 1, -1);
      start1 = 1'b1; len1 = 15'd1;
      @(negedge clk); start1 = 1'b0;
      chk("t1_busy_c1", int'(busy1), 1);
      chk("t1_tape_c1", int'(tape1), 1);
      wait_until(t0 + 257);
      chk("t1_done_c257", int'(done1), 1);
      chk("t1_pos", int'(pos1), 1);
      @(negedge clk);
      chk("t1_busy_after", int'(busy1), 0);
      chk("t1_done_after", int'(done1), 0);

      // 2: three bytes, repeated start while busy, address range
      mem1[0] = 8'hFF; mem1[1] = 8'h00; mem1[2] = 8'h3C; mem1[3] = 8'hEE;
      repeat (3) @(negedge clk);
      t0 = cyc;
      addr_max = 0; track = 1'b1;
      push_play(1'b0, t0, 1, 32'h003C_00FF, 3, -1);
      start1 = 1'b1; len1 = 15'd3;
      @(negedge clk); start1 = 1'b0;
      wait_until(t0 + 50);
      start1 = 1'b1; len1 = 15'd1;
      @(negedge clk); start1 = 1'b0; len1 = 15'd3;
      wait_until(t0 + 1 + 32 * BC);
      chk("t2_done", int'(done1), 1);
      chk("t2_pos", int'(pos1), 3);
      repeat (2) @(negedge clk);
      track = 1'b0;
      chk("t2_addr_max", addr_max, 2);
      chk("t2_busy_after", int'(busy1), 0);

      // 5: start with length 0 is ignored; start+stop together in IDLE too
      start1 = 1'b1; len1 = 15'd0;
      @(negedge clk); start1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_len0_busy", int'(busy1), 0);
      start1 = 1'b1; stop1 = 1'b1; len1 = 15'd2;
      @(negedge clk); start1 = 1'b0; stop1 = 1'b0;
      @(negedge clk);
      chk("t5_startstop_busy", int'(busy1), 0);

      // 4: stop at c=12 of cell 17 (byte 1 bit 1), then replay
      mem1[0] = 8'h12; mem1[1] = 8'h34; mem1[2] = 8'h56; mem1[3] = 8'h78;
      t0 = cyc;
      push_play(1'b0, t0, 1, 32'h7856_3412, 4, 18);
      start1 = 1'b1; len1 = 15'd4;
      @(negedge clk); start1 = 1'b0;
      wait_until(t0 + 1 + 17 * BC + 12);
      stop1 = 1'b1;
      @(negedge clk); stop1 = 1'b0;
      chk("t4_busy_after_stop", int'(busy1), 0);
      chk("t4_tape_after_stop", int'(tape1), 0);
      chk("t4_pos_after_stop", int'(pos1), 1);
      repeat (20) @(negedge clk);
      chk("t4_busy_later", int'(busy1), 0);
      chk("t4_sb_drained", sbq1.size(), 0);
      t0 = cyc;
      push_play(1'b0, t0, 1, 32'h7856_3412, 4, -1);
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      chk("t4_replay_pos_clr", int'(pos1), 0);
      wait_until(t0 + 1 + 40 * BC);
      chk("t4_replay_done", int'(done1), 1);
      chk("t4_replay_pos", int'(pos1), 4);
      repeat (3) @(negedge clk);

      // 3: no leader, 0x01: pulses at relative cycles 3 and 11, done at 131
      mem0[0] = 8'h01;
      t0 = cyc;
      push_play(1'b1, t0, 0, 32'h0000_0001, 1, -1);
      start0 = 1'b1; len0 = 15'd1;
      @(negedge clk); start0 = 1'b0;
      chk("t3_busy_c1", int'(busy0), 1);
      wait_until(t0 + 2);
      chk("t3_tape_c2", int'(tape0), 0);
      wait_until(t0 + 3);
      chk("t3_tape_c3", int'(tape0), 1);
      wait_until(t0 + 11);
      chk("t3_tape_c11", int'(tape0), 1);
      wait_until(t0 + 131);
      chk("t3_done_c131", int'(done0), 1);
      @(negedge clk);
      chk("t3_busy_after", int'(busy0), 0);

      // 6: asynchronous reset at c=12 of cell 20 (byte 1 bit 4)
      t0 = cyc;
      push_play(1'b0, t0, 1, 32'h7856_3412, 4, 21);
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      wait_until(t0 + 1 + 20 * BC + 12);
      chk("t6_pos_before", int'(pos1), 1);
      chk("t6_addr_before", int'(addr1), 1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_tape", int'(tape1), 0);
      chk("t6_rst_busy", int'(busy1), 0);
      chk("t6_rst_done", int'(done1), 0);
      chk("t6_rst_pos", int'(pos1), 0);
      chk("t6_rst_addr", int'(addr1), 0);
      @(negedge clk); reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("t6_idle_busy", int'(busy1), 0);

      chk("sb1_empty", sbq1.size(), 0);
      chk("sb0_empty", sbq0.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
